// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// A transfer happens on any rising edge where tx_valid and tx_ready are both high.
`timescale 1ns/1ps
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop; bit period from baudrate.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the FSM.
`timescale 1ns/1ps
// state  | meaning
// IDLE   | line high, waiting for a byte (handshake or FIFO head)
// START  | line low for one bit period
// DATA   | shifting out bit0..bit7, one bit period each
// PARITY | even parity bit for one bit period
// STOP   | line high for one bit period, then back to IDLE
module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baudrate,
    uart_tx_if.slave    tx,
    output logic        dataline,
    output logic        busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [2:0]  state;
    logic [15:0] bp;
    logic [15:0] cnt;
    logic [7:0]  shreg;
    logic        parity;
    logic [2:0]  bidx;
    logic        bit_end;
    logic        start_frame;
    logic [7:0]  start_byte;

    assign bit_end = (cnt == bp - 16'd1);

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign tx.tx_ready = !full && !rst;
    assign push        = tx.tx_valid && tx.tx_ready;
    assign pop         = (state == S_IDLE) && !empty;
    assign start_frame = pop;
    assign start_byte  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx.tx_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    assign tx.tx_ready = (state == S_IDLE) && !rst;
    assign start_frame = tx.tx_valid && tx.tx_ready;
    assign start_byte  = tx.tx_data;
`endif

    // dataline is registered from the next state, so the line changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dataline <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            bp       <= 16'd1;
            bidx     <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    dataline <= 1'b1;
                    cnt      <= '0;
                    if (start_frame) begin
                        shreg    <= start_byte;
                        parity   <= ^start_byte;
                        bp       <= (baudrate < 16'd2) ? 16'd1 : baudrate;
                        bidx     <= '0;
                        busy     <= 1'b1;
                        dataline <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        dataline <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bidx == 3'd7) begin
                            dataline <= parity;
                            state    <= S_PARITY;
                        end else begin
                            bidx     <= bidx + 3'd1;
                            shreg    <= {1'b0, shreg[7:1]};
                            dataline <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        dataline <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        busy     <= 1'b0;
                        dataline <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    dataline <= 1'b1;
                    busy     <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line samples each cycle compared against an expected waveform
// built from the frame rules (start, LSB-first data, even parity, stop, bit period from baudrate).
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baudrate = 16'd8;
    logic        dataline;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    logic cap_line[$];
    logic cap_busy[$];
    logic exp_line[$];
    logic exp_busy[$];

    uart_tx_if tx ();

    uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .baudrate (baudrate),
        .tx       (tx),
        .dataline (dataline),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void clear_all();
        cap_line.delete();
        cap_busy.delete();
        exp_line.delete();
        exp_busy.delete();
    endfunction

    function automatic void exp_idle(input int n);
        repeat (n) begin
            exp_line.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endfunction

    function automatic void exp_frame(input logic [7:0] d, input int baud);
        int   period;
        int   ones;
        logic bits[11];
        period = (baud < 2) ? 1 : baud;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = (ones % 2 == 1);
        bits[10] = 1'b1;
        for (int b = 0; b < 11; b++) begin
            repeat (period) begin
                exp_line.push_back(bits[b]);
                exp_busy.push_back(1'b1);
            end
        end
    endfunction

    function automatic int first_diff();
        if (cap_line.size() != exp_line.size()) return 0;
        for (int i = 0; i < exp_line.size(); i++)
            if (cap_line[i] !== exp_line[i] || cap_busy[i] !== exp_busy[i]) return i;
        return -1;
    endfunction

    // Records one sample per cycle at the falling edge; releases tx_valid after it is accepted.
    task automatic capture(input int n);
        bit drop;
        for (int i = 0; i < n; i++) begin
            cap_line.push_back(dataline);
            cap_busy.push_back(busy);
            drop = tx.tx_valid && tx.tx_ready;
            @(negedge clk);
            if (drop) tx.tx_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            checks += 3;
            if (dataline !== 1'b1) begin errors++; $display("FAIL reset_dataline: got %b want 1", dataline); end
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
            if (tx.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", tx.tx_ready); end
        end
        rst = 1'b0;
        tx.tx_valid = 1'b0;
        #1;
        checks++;
        if (tx.tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", tx.tx_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic(input logic [7:0] d, input logic [15:0] baud, input string name);
        int k;
        clear_all();
        baudrate = baud;
        tx.tx_data = d;
        tx.tx_valid = 1'b1;
        checks++;
        if (tx.tx_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", name, tx.tx_ready); end
        exp_idle(1 + LAT);
        exp_frame(d, int'(baud));
        exp_idle(2);
        capture(exp_line.size());
        k = first_diff();
        checks++;
        if (k >= 0) begin
            errors++;
            $display("FAIL %s_frame: sample %0d line=%b busy=%b, want line=%b busy=%b",
                     name, k, cap_line[k], cap_busy[k], exp_line[k], exp_busy[k]);
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [15:0] b;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            b = 16'($urandom_range(1, 5));
            test_basic(d, b, "random");
        end
    endtask

    task automatic test_back_to_back();
        int k;
        clear_all();
        baudrate = 16'd8;
        tx.tx_data = 8'h07;
        tx.tx_valid = 1'b1;
        exp_idle(1 + LAT);
        exp_frame(8'h07, 8);
        exp_idle(1);
        exp_frame(8'h0F, 8);
        exp_idle(2);
        capture(2);
        tx.tx_data = 8'h0F;
        tx.tx_valid = 1'b1;
        capture(exp_line.size() - 2);
        k = first_diff();
        checks++;
        if (k >= 0) begin
            errors++;
            $display("FAIL back_to_back: sample %0d line=%b busy=%b, want line=%b busy=%b",
                     k, cap_line[k], cap_busy[k], exp_line[k], exp_busy[k]);
        end
    endtask

    task automatic test_baud();
        logic [7:0] d;
        int k;
        test_basic(8'($urandom), 16'd1, "baud1");
        test_basic(8'($urandom), 16'd0, "baud0");
        // Change baudrate mid-frame: current frame keeps 2-cycle bits.
        clear_all();
        d = 8'($urandom);
        baudrate = 16'd2;
        tx.tx_data = d;
        tx.tx_valid = 1'b1;
        exp_idle(1 + LAT);
        exp_frame(d, 2);
        exp_idle(2);
        capture(6);
        baudrate = 16'd8;
        capture(exp_line.size() - 6);
        k = first_diff();
        checks++;
        if (k >= 0) begin
            errors++;
            $display("FAIL baud_midframe: sample %0d line=%b busy=%b, want line=%b busy=%b",
                     k, cap_line[k], cap_busy[k], exp_line[k], exp_busy[k]);
        end
        test_basic(8'($urandom), 16'd8, "baud_next");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int n;
        int k;
        clear_all();
        baudrate = 16'd8;
        d = 8'($urandom);
        n = 1 + LAT + 8 * 4 + 3;
        exp_idle(1 + LAT);
        exp_frame(d, 8);
        while (exp_line.size() > n) begin
            void'(exp_line.pop_back());
            void'(exp_busy.pop_back());
        end
        tx.tx_data = d;
        tx.tx_valid = 1'b1;
        capture(1);
        tx.tx_data = 8'($urandom);
        tx.tx_valid = 1'b1;
        capture(1);
        tx.tx_valid = 1'b0;
        capture(n - 2);
        k = first_diff();
        checks++;
        if (k >= 0) begin
            errors++;
            $display("FAIL reset_mid_prefix: sample %0d line=%b busy=%b, want line=%b busy=%b",
                     k, cap_line[k], cap_busy[k], exp_line[k], exp_busy[k]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (dataline !== 1'b1) begin errors++; $display("FAIL reset_mid_dataline: got %b want 1", dataline); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        if (tx.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready: got %b want 0", tx.tx_ready); end
        rst = 1'b0;
        @(negedge clk);
        // Long idle tail: nothing queued before the reset may come out.
        clear_all();
        tx.tx_data = 8'hA5;
        tx.tx_valid = 1'b1;
        exp_idle(1 + LAT);
        exp_frame(8'hA5, 8);
        exp_idle(2 * 11 * 8);
        capture(exp_line.size());
        k = first_diff();
        checks++;
        if (k >= 0) begin
            errors++;
            $display("FAIL reset_mid_a5: sample %0d line=%b busy=%b, want line=%b busy=%b",
                     k, cap_line[k], cap_busy[k], exp_line[k], exp_busy[k]);
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo();
        logic [7:0] b[5];
        int  cnt_m;
        bit  popped;
        bit  pop;
        bit  exp_r;
        int  k;
        clear_all();
        baudrate = 16'd2;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        cnt_m = 0;
        popped = 0;
        for (int i = 0; i < 5; i++) begin
            tx.tx_data = b[i];
            tx.tx_valid = 1'b1;
            exp_r = (cnt_m < DEPTH);
            checks++;
            if (tx.tx_ready !== exp_r) begin errors++; $display("FAIL fifo_push%0d_ready: got %b want %b", i, tx.tx_ready, exp_r); end
            pop = !popped && cnt_m > 0;
            if (pop) popped = 1;
            cnt_m = cnt_m + (exp_r ? 1 : 0) - (pop ? 1 : 0);
            @(negedge clk);
        end
        tx.tx_valid = 1'b0;
        exp_r = (cnt_m < DEPTH);
        checks++;
        if (tx.tx_ready !== exp_r) begin errors++; $display("FAIL fifo_full_ready: got %b want %b", tx.tx_ready, exp_r); end
        // First frame started after the second push edge, so three of its samples are already past.
        exp_frame(b[0], 2);
        repeat (3) begin
            void'(exp_line.pop_front());
            void'(exp_busy.pop_front());
        end
        for (int i = 1; i < 5; i++) begin
            exp_idle(1);
            exp_frame(b[i], 2);
        end
        exp_idle(2);
        capture(exp_line.size());
        k = first_diff();
        checks++;
        if (k >= 0) begin
            errors++;
            $display("FAIL fifo_order: sample %0d line=%b busy=%b, want line=%b busy=%b",
                     k, cap_line[k], cap_busy[k], exp_line[k], exp_busy[k]);
        end
    endtask
`endif

    initial begin
        tx.tx_data = 8'h00;
        tx.tx_valid = 1'b0;
        test_reset();
        test_basic(8'h55, 16'd8, "send55");
        test_back_to_back();
        test_baud();
        test_reset_mid();
        test_random();
`ifdef UART_TX_FIFO_EN
        test_fifo();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
